// File: rtl/mux_tree_sel.sv
// mux_tree_sel: N-input, WIDTH-bit selector built as a balanced tree of
// 2:1 and 4:1 mux primitives, with a load-enabled registered copy of the result.
// The tree uses 4:1 levels first, taking select bits two at a time from the LSB.
// An odd select width leaves one bit, which drives a single 2:1 root.

// Two-input mux in gate form: inverter on the select, two ANDs, one OR.
module mux_tree_sel_mux2 #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  logic             s_n;
  logic [WIDTH-1:0] and0;
  logic [WIDTH-1:0] and1;

  assign s_n  = ~s;
  assign and0 = i0 & {WIDTH{s_n}};
  assign and1 = i1 & {WIDTH{s}};
  assign y    = and0 | and1;

endmodule

// Four-input mux: two 2:1 muxes on s[0] feeding one 2:1 mux on s[1].
module mux_tree_sel_mux4 #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic [1:0]       s,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;

  mux_tree_sel_mux2 #(.WIDTH(WIDTH)) u_lo   (.i0(i0), .i1(i1), .s(s[0]), .y(lo));
  mux_tree_sel_mux2 #(.WIDTH(WIDTH)) u_hi   (.i0(i2), .i1(i3), .s(s[0]), .y(hi));
  mux_tree_sel_mux2 #(.WIDTH(WIDTH)) u_root (.i0(lo), .i1(hi), .s(s[1]), .y(y));

endmodule

module mux_tree_sel #(
  parameter int N_INPUTS = 8,
  parameter int WIDTH    = 1,
  parameter int SEL_W    = $clog2(N_INPUTS)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [N_INPUTS*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      load_en,
  output logic [WIDTH-1:0]          out_comb,
  output logic [WIDTH-1:0]          out_q,
  output logic                      out_valid
);

  // Index of the first node of a given tree level inside the flat node vector.
  // Level 0 holds the N_INPUTS data inputs; each 4:1 level holds a quarter
  // as many nodes as the level before it.
  function automatic int level_base(input int lvl);
    int b;
    b = 0;
    for (int j = 0; j < lvl; j++) begin
      b += N_INPUTS >> (2 * j);
    end
    return b;
  endfunction

  localparam int  L4        = SEL_W / 2;
  localparam bit  ODD_SEL   = (SEL_W % 2) == 1;
  localparam int  ROOT_BASE = level_base(L4);
  localparam int  TOTAL     = ODD_SEL ? ROOT_BASE + 3 : ROOT_BASE + 1;

  // Every tree node, level after level, WIDTH bits each; the last node is the result.
  logic [TOTAL*WIDTH-1:0] node;

  assign node[0 +: N_INPUTS*WIDTH] = data_in;

  // 4:1 levels: level l combines groups of four nodes using sel[2l+1:2l].
  for (genvar l = 0; l < L4; l++) begin : g_lvl
    localparam int CNT = N_INPUTS >> (2 * (l + 1));
    localparam int SRC = level_base(l);
    localparam int DST = level_base(l + 1);
    for (genvar m = 0; m < CNT; m++) begin : g_mux
      mux_tree_sel_mux4 #(.WIDTH(WIDTH)) u_mux4 (
        .i0(node[(SRC + 4*m + 0)*WIDTH +: WIDTH]),
        .i1(node[(SRC + 4*m + 1)*WIDTH +: WIDTH]),
        .i2(node[(SRC + 4*m + 2)*WIDTH +: WIDTH]),
        .i3(node[(SRC + 4*m + 3)*WIDTH +: WIDTH]),
        .s (sel[2*l +: 2]),
        .y (node[(DST + m)*WIDTH +: WIDTH])
      );
    end
  end

  // With an odd select width two nodes remain, chosen by the top select bit.
  if (ODD_SEL) begin : g_root2
    mux_tree_sel_mux2 #(.WIDTH(WIDTH)) u_mux2 (
      .i0(node[(ROOT_BASE + 0)*WIDTH +: WIDTH]),
      .i1(node[(ROOT_BASE + 1)*WIDTH +: WIDTH]),
      .s (sel[SEL_W-1]),
      .y (node[(ROOT_BASE + 2)*WIDTH +: WIDTH])
    );
  end

  assign out_comb = node[(TOTAL-1)*WIDTH +: WIDTH];

  // Output register: cleared at once by reset, otherwise captures the tree result when load_en is high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q     <= '0;
      out_valid <= 1'b0;
    end else if (load_en) begin
      out_q     <= out_comb;
      out_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mux_tree_sel.sv
// Bench for mux_tree_sel: several tree sizes checked through one scoreboard queue.
`timescale 1ps/1ps
module tb_mux_tree_sel;

  typedef enum int {S8C, S4C, S4Q, S4V, S2C, S32C, S64Q, S64V} src_e;
  typedef struct {
    string      tag;
    src_e       src;
    logic [7:0] exp;
  } item_t;

  item_t sbq[$];
  int    compared   = 0;
  int    mismatched = 0;
  logic  strobe     = 1'b0;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic rst4_n  = 1'b0;

  // N=8, WIDTH=1
  logic [7:0]   data8 = '0;
  logic [2:0]   sel8  = '0;
  logic         out8c, out8q, out8v;
  // N=4, WIDTH=8
  logic [31:0]  data4 = '0;
  logic [1:0]   sel4  = '0;
  logic         load4 = 1'b0;
  logic [7:0]   out4c, out4q;
  logic         out4v;
  // N=2, WIDTH=4
  logic [7:0]   data2 = '0;
  logic         sel2  = 1'b0;
  logic [3:0]   out2c, out2q;
  logic         out2v;
  // N=32, WIDTH=4
  logic [127:0] data32 = '0;
  logic [4:0]   sel32  = '0;
  logic [3:0]   out32c, out32q;
  logic         out32v;
  // N=64, WIDTH=4
  logic [255:0] data64 = '0;
  logic [5:0]   sel64  = '0;
  logic         load64 = 1'b0;
  logic [3:0]   out64c, out64q;
  logic         out64v;

  always #1000 clk = ~clk;

  mux_tree_sel #(.N_INPUTS(8), .WIDTH(1)) u8 (
    .clk(clk), .reset_n(rst_n), .data_in(data8), .sel(sel8), .load_en(1'b0),
    .out_comb(out8c), .out_q(out8q), .out_valid(out8v));

  mux_tree_sel #(.N_INPUTS(4), .WIDTH(8)) u4 (
    .clk(clk), .reset_n(rst4_n), .data_in(data4), .sel(sel4), .load_en(load4),
    .out_comb(out4c), .out_q(out4q), .out_valid(out4v));

  mux_tree_sel #(.N_INPUTS(2), .WIDTH(4)) u2 (
    .clk(clk), .reset_n(rst_n), .data_in(data2), .sel(sel2), .load_en(1'b0),
    .out_comb(out2c), .out_q(out2q), .out_valid(out2v));

  mux_tree_sel #(.N_INPUTS(32), .WIDTH(4)) u32 (
    .clk(clk), .reset_n(rst_n), .data_in(data32), .sel(sel32), .load_en(1'b0),
    .out_comb(out32c), .out_q(out32q), .out_valid(out32v));

  mux_tree_sel #(.N_INPUTS(64), .WIDTH(4)) u64 (
    .clk(clk), .reset_n(rst_n), .data_in(data64), .sel(sel64), .load_en(load64),
    .out_comb(out64c), .out_q(out64q), .out_valid(out64v));

  function automatic logic [7:0] read_actual(input src_e s);
    logic [7:0] r;
    r = '0;
    case (s)
      S8C:  r[0]   = out8c;
      S4C:  r      = out4c;
      S4Q:  r      = out4q;
      S4V:  r[0]   = out4v;
      S2C:  r[3:0] = out2c;
      S32C: r[3:0] = out32c;
      S64Q: r[3:0] = out64q;
      S64V: r[0]   = out64v;
      default: r = 'x;
    endcase
    return r;
  endfunction

  // Queue an expected value; the monitor compares it at the next strobe.
  task automatic checkOutput(input string tag, input src_e s, input logic [7:0] v);
    item_t e;
    e.tag = tag;
    e.src = s;
    e.exp = v;
    sbq.push_back(e);
  endtask

  // Tell the monitor the outputs are settled and ready to be compared.
  task automatic sampleNow();
    strobe = ~strobe;
    #1;
  endtask

  // One step of the exhaustive N=8 sweep: {sel,data_in} = k.
  task automatic applyStimulus(input int k);
    logic [10:0] kv;
    logic [7:0]  d;
    kv    = k[10:0];
    d     = kv[7:0];
    sel8  = kv[10:8];
    data8 = d;
    #500;
    checkOutput("sweep8_comb", S8C, {7'b0, d[kv[10:8]]});
    sampleNow();
  endtask

  // Monitor: on each strobe drain the queue and compare against the DUT outputs.
  initial begin : monitor
    item_t      e;
    logic [7:0] act;
    forever begin
      @(strobe);
      while (sbq.size() > 0) begin
        e   = sbq.pop_front();
        act = read_actual(e.src);
        compared++;
        if (act !== e.exp) begin
          mismatched++;
          $display("[TB] FAIL %s: got %h expected %h", e.tag, act, e.exp);
        end
      end
    end
  end

  initial begin : watchdog
    #20000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    for (int k = 0; k < 32; k++) data32[k*4 +: 4] = 4'((k * 7 + 3) % 16);
    for (int k = 0; k < 64; k++) data64[k*4 +: 4] = 4'((k * 5 + 1) % 16);

    // Reset state
    #100;
    checkOutput("reset_q4", S4Q, 8'h00);
    checkOutput("reset_v4", S4V, 8'h00);
    checkOutput("reset_q64", S64Q, 8'h00);
    checkOutput("reset_v64", S64V, 8'h00);
    sampleNow();
    @(negedge clk);
    rst_n  = 1'b1;
    rst4_n = 1'b1;

    // Exhaustive N=8 sweep
    for (int k = 0; k < 2048; k++) applyStimulus(k);

    // Top input selected, then input 0
    data8 = 8'b1000_0000;
    sel8  = 3'd7;
    #500;
    checkOutput("tog_sel7", S8C, 8'h01);
    sampleNow();
    sel8 = 3'd0;
    #450;
    checkOutput("tog_sel0_450", S8C, 8'h00);
    sampleNow();
    #49;
    checkOutput("tog_sel0_500", S8C, 8'h00);
    sampleNow();

    // N=4 WIDTH=8 load and hold
    @(negedge clk);
    data4 = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    sel4  = 2'd2;
    load4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("load_q", S4Q, 8'hCC);
    checkOutput("load_v", S4V, 8'h01);
    checkOutput("load_c", S4C, 8'hCC);
    sampleNow();
    load4 = 1'b0;
    sel4  = 2'd3;
    @(posedge clk);
    @(negedge clk);
    checkOutput("hold_q", S4Q, 8'hCC);
    checkOutput("hold_v", S4V, 8'h01);
    checkOutput("hold_c", S4C, 8'hDD);
    sampleNow();

    // Asynchronous reset between edges
    #300;
    rst4_n = 1'b0;
    #1;
    checkOutput("async_rst_q", S4Q, 8'h00);
    checkOutput("async_rst_v", S4V, 8'h00);
    checkOutput("async_rst_c", S4C, 8'hDD);
    sampleNow();

    // Reset release together with load_en
    @(negedge clk);
    rst4_n = 1'b1;
    sel4   = 2'd0;
    load4  = 1'b1;
    #1;
    checkOutput("rel_pre_q", S4Q, 8'h00);
    checkOutput("rel_pre_v", S4V, 8'h00);
    sampleNow();
    @(posedge clk);
    @(negedge clk);
    checkOutput("rel_first_q", S4Q, 8'hAA);
    checkOutput("rel_first_v", S4V, 8'h01);
    sampleNow();

    // Mid-cycle select change reaches out_comb only
    @(posedge clk);
    #300;
    sel4 = 2'd1;
    #200;
    checkOutput("midcyc_c", S4C, 8'hBB);
    checkOutput("midcyc_q", S4Q, 8'hAA);
    sampleNow();
    load4 = 1'b0;

    // N=2 single 2:1 root
    data2 = 8'h5A;
    sel2  = 1'b0;
    #500;
    checkOutput("n2_sel0", S2C, 8'h0A);
    sampleNow();
    sel2 = 1'b1;
    #500;
    checkOutput("n2_sel1", S2C, 8'h05);
    sampleNow();

    // N=32, odd select width
    for (int s = 0; s < 32; s++) begin
      sel32 = 5'(s);
      #500;
      checkOutput("n32_comb", S32C, {4'h0, 4'((s * 7 + 3) % 16)});
      sampleNow();
    end

    // N=64 WIDTH=4 pipelined capture after reset
    @(negedge clk);
    rst_n  = 1'b0;
    load64 = 1'b1;
    sel64  = 6'd0;
    #1;
    checkOutput("n64_rst_q", S64Q, 8'h00);
    checkOutput("n64_rst_v", S64V, 8'h00);
    sampleNow();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) begin
      sel64 = 6'(i);
      checkOutput("n64_q", S64Q, {4'h0, 4'((i * 5 + 1) % 16)});
      checkOutput("n64_v", S64V, 8'h01);
      @(posedge clk);
      #1;
      sampleNow();
      @(negedge clk);
    end

    #10;
    sampleNow();
    if (sbq.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard_drain: got %0d left expected 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mux_tree_sel.md
Name: mux_tree_sel

Overview:
- Parameterized N-input, WIDTH-bit selector built only from 2:1 and 4:1 mux primitives arranged as a balanced tree.
- The primitives have the same behaviour as the datapath's existing mux2_1 and mux4_1 cells.
- Provides a combinational result and a registered copy of it.
- Used in the register-file read path and the ALU result selection, where a multiplexer critical path must be known exactly.

Parameters:
- N_INPUTS, 8, number of data inputs; must be a power of two, 2..64.
- WIDTH, 1, bit width of each data input and of the outputs.
- SEL_W, $clog2(N_INPUTS), select width; derived, not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- data_in  input  N_INPUTS*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- sel  input  SEL_W  index of the input to pass.
- load_en  input  1  when high, the output register captures the combinational result.
- out_comb  output  WIDTH  combinational selected value.
- out_q  output  WIDTH  registered selected value.
- out_valid  output  1  high once out_q holds a captured value since reset.

Behaviour:
- Combinational function: out_comb = data_in[sel*WIDTH +: WIDTH] for every sel value.
  - No invalid sel values exist, because N_INPUTS is a power of two.
  - No latches; out_comb is never X when its inputs are known.
- Primitive mux2_1: out = sel ? i1 : i0.
  - Gate-level form: two AND gates, one inverter on sel, one OR gate.
  - Each gate has a 50 ps delay.
- Primitive mux4_1: out = i[sel[1:0]].
  - Built from two mux2_1 on sel[0] feeding one mux2_1 on sel[1].
- Tree construction:
  - Leaf levels use mux4_1 groups, consuming two select bits per level, LSB first.
  - If SEL_W is odd, the final (root) level is a single mux2_1 driven by sel[SEL_W-1].
  - N_INPUTS=8: two mux4_1 on sel[1:0] (inputs 0-3 and 4-7), then a mux2_1 on sel[2].
  - Worst-case delay for N_INPUTS=8 is 450 ps; the stimulus settle interval is 500 ps.
- Register behaviour:
  - On reset_n low, immediately and asynchronously: out_q = 0, out_valid = 0.
  - On the rising edge of clk with reset_n high and load_en=1: out_q <= out_comb and out_valid <= 1.
  - With load_en=0, out_q and out_valid hold their values.
  - Latency from data_in/sel to out_q is 1 clock.
- Reset mid-operation clears out_q and out_valid at once, regardless of clk.
  - The combinational path is unaffected by reset.
- Reset released in the same cycle as load_en=1: the first capture occurs at the first rising edge after reset_n goes high.
- Changes to data_in or sel between clock edges affect only out_comb, never out_q.

Test Plan:
- N_INPUTS=8, WIDTH=1: iterate k=0..2047 with {sel,data_in}=k, holding each for 500 ps -> out_comb == data_in[sel] every step; there are 2048 checks and no X values.
- data_in=8'b1000_0000, sel toggles 3'd7 -> 3'd0 -> out_comb goes 1 -> 0 within 450 ps and is stable at the 500 ps sample.
- WIDTH=8, N_INPUTS=4, data_in={8'hDD,8'hCC,8'hBB,8'hAA}, sel=2, load_en=1 -> out_q=8'hCC one clock later; then load_en=0 and sel=3 -> out_q stays 8'hCC while out_comb=8'hDD.
- Assert reset_n=0 between clock edges while out_q=8'hCC -> out_q=0 and out_valid=0 immediately, before the next edge.
- N_INPUTS=2 (single mux2_1 root) and N_INPUTS=32 (odd SEL_W=5): random data, sweep all sel values -> out_comb matches the indexed slice for every sel.
- N_INPUTS=64, WIDTH=4, load_en=1 with sel incrementing each clock -> out_q equals the slice selected on the previous cycle, and out_valid=1 from the first edge after reset.
